// File: rtl/ik_pkg.sv
// Shared definitions for the IK iteration controller.
// Holds the controller state encoding, the default fixed-point word type,
// and pi constants derived from the number of fractional bits.
package ik_pkg;

  localparam int unsigned WORD_W   = 36;
  localparam int unsigned FRAC_DEF = 20;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    UPDATE = 3'd3,
    FINISH = 3'd4
  } state_e;

  // pi with 60 fractional bits; the next hex digit is 3, so the value is rounded down.
  localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

  // pi rounded to nearest at the given number of fractional bits (frac <= 59)
  function automatic logic [63:0] pi_fx(input int unsigned frac);
    logic [63:0] r;
    r = PI_Q60 + (64'd1 << (59 - frac));
    return r >> (60 - frac);
  endfunction

  function automatic logic [63:0] two_pi_fx(input int unsigned frac);
    return pi_fx(frac) << 1;
  endfunction

  localparam logic [63:0] PI     = pi_fx(FRAC_DEF);
  localparam logic [63:0] TWO_PI = two_pi_fx(FRAC_DEF);

endpackage

// File: rtl/ik_joint_update.sv
// Combinational update for one joint.
// Clamps the core delta to +/-max_step and adds it to the current value.
// Revolute joints wrap into [-pi, pi]; prismatic joints saturate to the word
// range. Also reports whether the unclamped delta magnitude is within tol.
//   revolute     : 1 = angle joint, 0 = prismatic
//   cur          : current joint value
//   delta        : raw delta from the IK core
//   max_step     : positive step clamp
//   tol          : non-negative convergence tolerance
//   next_c       : updated joint value
//   within_tol_c : |delta| <= tol
module ik_joint_update
  import ik_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned FRAC  = 20
) (
  input  logic             revolute,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] delta,
  input  logic [WIDTH-1:0] max_step,
  input  logic [WIDTH-1:0] tol,
  output logic [WIDTH-1:0] next_c,
  output logic             within_tol_c
);

  // One guard bit keeps sums, negations and 2*pi free of overflow.
  localparam int unsigned SW = WIDTH + 1;

  localparam logic signed [SW-1:0] PI_S     = $signed(SW'(pi_fx(FRAC)));
  localparam logic signed [SW-1:0] TWO_PI_S = $signed(SW'(two_pi_fx(FRAC)));
  localparam logic signed [SW-1:0] MAX_S    = $signed({2'b00, {(WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN_S    = $signed({2'b11, {(WIDTH-1){1'b0}}});

  logic signed [SW-1:0] d_s;
  logic signed [SW-1:0] ms_s;
  logic signed [SW-1:0] clamped;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] res;
  logic signed [SW-1:0] mag;

  // clamp, add, then wrap or saturate depending on joint type
  always_comb begin
    d_s  = $signed({delta[WIDTH-1], delta});
    ms_s = $signed({1'b0, max_step});

    clamped = d_s;
    if (d_s > ms_s) begin
      clamped = ms_s;
    end else if (d_s < -ms_s) begin
      clamped = -ms_s;
    end

    sum = $signed({cur[WIDTH-1], cur}) + clamped;
    res = sum;
    if (revolute) begin
      if (sum > PI_S) begin
        res = sum - TWO_PI_S;
      end else if (sum < -PI_S) begin
        res = sum + TWO_PI_S;
      end
    end else begin
      if (sum > MAX_S) begin
        res = MAX_S;
      end else if (sum < MIN_S) begin
        res = MIN_S;
      end
    end
    next_c = res[WIDTH-1:0];
  end

  // magnitude of the raw delta; the most-negative word counts as max positive
  always_comb begin
    if (d_s == MIN_S) begin
      mag = MAX_S;
    end else if (d_s < 0) begin
      mag = -d_s;
    end else begin
      mag = d_s;
    end
    within_tol_c = (mag <= $signed({1'b0, tol}));
  end

endmodule

// File: rtl/ik_iter_ctrl.sv
// Iteration controller for an inverse-kinematics solver.
// Loads initial joint values, repeatedly asks the IK core for a delta,
// applies clamped/wrapped updates and stops on convergence, iteration limit
// or abort.
//   clk, rst           : clock, asynchronous active-high reset
//   start, abort       : begin a solve when idle / terminate an active solve
//   joint_type         : per joint, 1 = revolute, 0 = prismatic
//   dh_init            : initial joint values (sampled on start)
//   max_iter, tol,
//   max_step           : solve limits (sampled on start)
//   core_en            : request one delta from the IK core (level)
//   core_done, delta   : IK core result strobe and joint deltas
//   dh_dyn_out         : current joint values
//   busy, done         : solve in progress / one-cycle end-of-solve pulse
//   converged          : last solve met tolerance
//   iter_count         : iterations completed in current/last solve
module ik_iter_ctrl
  import ik_pkg::*;
#(
  parameter int unsigned N_JOINTS = 6,
  parameter int unsigned WIDTH    = 36,
  parameter int unsigned FRAC     = 20,
  parameter int unsigned ITER_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [N_JOINTS-1:0]            joint_type,
  input  logic [N_JOINTS-1:0][WIDTH-1:0] dh_init,
  input  logic [ITER_W-1:0]              max_iter,
  input  logic [WIDTH-1:0]               tol,
  input  logic [WIDTH-1:0]               max_step,
  output logic                           core_en,
  input  logic                           core_done,
  input  logic [N_JOINTS-1:0][WIDTH-1:0] delta,
  output logic [N_JOINTS-1:0][WIDTH-1:0] dh_dyn_out,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic [ITER_W-1:0]              iter_count
);

  state_e state_q, state_d;

  logic [N_JOINTS-1:0][WIDTH-1:0] delta_q, delta_d;
  logic [N_JOINTS-1:0][WIDTH-1:0] dh_d;
  logic [N_JOINTS-1:0][WIDTH-1:0] upd_c;
  logic [N_JOINTS-1:0]            within_c;
  logic [ITER_W-1:0]              max_iter_q, max_iter_d;
  logic [WIDTH-1:0]               tol_q, tol_d;
  logic [WIDTH-1:0]               max_step_q, max_step_d;
  logic [ITER_W-1:0]              iter_d;
  logic                           conv_d;
  logic                           core_en_d, busy_d, done_d;
  logic                           limit_hit_c;

  // per-joint datapath works on the captured delta and the current values
  for (genvar g = 0; g < N_JOINTS; g++) begin : g_joint
    ik_joint_update #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_joint (
      .revolute     (joint_type[g]),
      .cur          (dh_dyn_out[g]),
      .delta        (delta_q[g]),
      .max_step     (max_step_q),
      .tol          (tol_q),
      .next_c       (upd_c[g]),
      .within_tol_c (within_c[g])
    );
  end

  // the iteration just completing reaches the latched limit
  assign limit_hit_c = ({1'b0, iter_count} + (ITER_W+1)'(1)) >= {1'b0, max_iter_q};

  // next-state and next register values
  always_comb begin
    state_d    = state_q;
    delta_d    = delta_q;
    dh_d       = dh_dyn_out;
    max_iter_d = max_iter_q;
    tol_d      = tol_q;
    max_step_d = max_step_q;
    iter_d     = iter_count;
    conv_d     = converged;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          dh_d       = dh_init;
          max_iter_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
          tol_d      = tol;
          max_step_d = max_step;
          delta_d    = '0;
          iter_d     = '0;
          conv_d     = 1'b0;
        end
      end
      LOAD: begin
        state_d = abort ? FINISH : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = FINISH;
        end else if (core_done) begin
          delta_d = delta;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (abort) begin
          state_d = FINISH;
        end else begin
          dh_d   = upd_c;
          iter_d = (&iter_count) ? iter_count : iter_count + ITER_W'(1);
          if (&within_c) begin
            conv_d  = 1'b1;
            state_d = FINISH;
          end else if (limit_hit_c) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    core_en_d = (state_d == RUN);
    busy_d    = (state_d == LOAD) || (state_d == RUN) || (state_d == UPDATE);
    done_d    = (state_d == FINISH);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      delta_q    <= '0;
      dh_dyn_out <= '0;
      max_iter_q <= '0;
      tol_q      <= '0;
      max_step_q <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      core_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      delta_q    <= delta_d;
      dh_dyn_out <= dh_d;
      max_iter_q <= max_iter_d;
      tol_q      <= tol_d;
      max_step_q <= max_step_d;
      iter_count <= iter_d;
      converged  <= conv_d;
      core_en    <= core_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_ik_iter_ctrl.sv
// Self-checking bench for ik_iter_ctrl: acts as the IK core and compares
// against a joint-value model computed with plain integer arithmetic.
module tb_ik_iter_ctrl;

  localparam int NJ = 6;
  localparam int W  = 36;
  localparam int FR = 20;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst, start, abort, core_done;
  logic core_en, busy, done, converged;
  logic [NJ-1:0]         joint_type;
  logic [NJ-1:0][W-1:0]  dh_init, delta, dh_dyn_out;
  logic [IW-1:0]         max_iter, iter_count;
  logic [W-1:0]          tol, max_step;

  int total = 0;
  int bad   = 0;

  longint pi_v, two_pi_v, wmax, wmin, ms_g;
  longint cur [NJ];
  longint dq  [NJ];
  logic [NJ-1:0] jt_g;

  ik_iter_ctrl #(.N_JOINTS(NJ), .WIDTH(W), .FRAC(FR), .ITER_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .joint_type (joint_type),
    .dh_init    (dh_init),
    .max_iter   (max_iter),
    .tol        (tol),
    .max_step   (max_step),
    .core_en    (core_en),
    .core_done  (core_done),
    .delta      (delta),
    .dh_dyn_out (dh_dyn_out),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint absv(input longint d);
    if (d == wmin) return wmax;
    return (d < 0) ? -d : d;
  endfunction

  // reference joint step: clamp, add, wrap angle or saturate length
  function automatic longint step_joint(input longint c, input longint d, input longint ms,
                                        input bit rev);
    longint cl, s;
    cl = (d > ms) ? ms : ((d < -ms) ? -ms : d);
    s  = c + cl;
    if (rev) begin
      if (s > pi_v) s = s - two_pi_v;
      else if (s < -pi_v) s = s + two_pi_v;
    end else begin
      if (s > wmax) s = wmax;
      else if (s < wmin) s = wmin;
    end
    return s;
  endfunction

  function automatic longint gen_delta(input int mode, input int j);
    logic [W-1:0] r;
    case (mode)
      0: gen_delta = longint'($urandom_range(0, 629146)) - 314573;
      1: gen_delta = 5243;
      2: gen_delta = 2097152;
      3: gen_delta = 104858;
      4: begin
        r = W'({$urandom, $urandom});
        gen_delta = sx(r);
      end
      5: gen_delta = wmin;
      default: gen_delta = (j % 2 == 0) ? ms_g : -ms_g;
    endcase
  endfunction

  // run one solve; abort_iter = iteration whose core_done carries abort (0 = none)
  task automatic do_solve(input string nm, input int max_it, input longint tol_v,
                          input longint ms_v, input int mode, input int abort_iter);
    int  eff, it, guard;
    bit  fin, conv, ab;
    eff  = (max_it == 0) ? 1 : max_it;
    it   = 0;
    fin  = 1'b0;
    conv = 1'b0;
    ms_g = ms_v;
    joint_type = jt_g;
    for (int j = 0; j < NJ; j++) dh_init[j] = W'(cur[j]);
    max_iter = IW'(max_it);
    tol      = W'(tol_v);
    max_step = W'(ms_v);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".load_busy"}, longint'(busy), longint'(1));
    chk({nm, ".load_iter"}, longint'(iter_count), longint'(0));
    chk({nm, ".load_dh0"}, sx(dh_dyn_out[0]), cur[0]);
    while (!fin) begin
      guard = 0;
      while (!core_en && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      chk({nm, ".core_en"}, longint'(core_en), longint'(1));
      if (!core_en) return;
      // start pulses while busy must be ignored
      repeat ($urandom_range(0, 2)) begin
        start = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
      for (int j = 0; j < NJ; j++) begin
        dq[j]    = gen_delta(mode, j);
        delta[j] = W'(dq[j]);
      end
      ab        = (it + 1 == abort_iter);
      core_done = 1'b1;
      abort     = ab;
      @(negedge clk);
      core_done = 1'b0;
      abort     = 1'b0;
      if (ab) begin
        fin  = 1'b1;
        conv = 1'b0;
      end else begin
        chk({nm, ".upd_core_en"}, longint'(core_en), longint'(0));
        conv = 1'b1;
        for (int j = 0; j < NJ; j++) begin
          if (absv(dq[j]) > tol_v) conv = 1'b0;
          cur[j] = step_joint(cur[j], dq[j], ms_v, jt_g[j]);
        end
        it  = (it < 255) ? it + 1 : 255;
        fin = conv || (it >= eff);
        @(negedge clk);
      end
    end
    chk({nm, ".done"}, longint'(done), longint'(1));
    chk({nm, ".busy_end"}, longint'(busy), longint'(0));
    chk({nm, ".converged"}, longint'(converged), longint'(conv));
    chk({nm, ".iter_count"}, longint'(iter_count), longint'(it));
    for (int j = 0; j < NJ; j++) chk($sformatf("%s.dh%0d", nm, j), sx(dh_dyn_out[j]), cur[j]);
    @(negedge clk);
    chk({nm, ".done_pulse"}, longint'(done), longint'(0));
    chk({nm, ".conv_hold"}, longint'(converged), longint'(conv));
  endtask

  initial begin
    pi_v     = longint'($floor(3.141592653589793 * 1048576.0 + 0.5));
    two_pi_v = 2 * pi_v;
    wmax     = (longint'(1) <<< (W - 1)) - 1;
    wmin     = -(longint'(1) <<< (W - 1));

    rst = 1'b1; start = 1'b0; abort = 1'b0; core_done = 1'b0;
    joint_type = '0; dh_init = '0; delta = '0;
    max_iter = '0; tol = '0; max_step = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", longint'(busy), longint'(0));
    chk("rst.core_en", longint'(core_en), longint'(0));
    chk("rst.iter", longint'(iter_count), longint'(0));
    chk("rst.dh", sx(dh_dyn_out[3]), longint'(0));
    rst = 1'b0;
    @(negedge clk);

    // small deltas under tolerance converge after one iteration
    jt_g = '1;
    for (int j = 0; j < NJ; j++) cur[j] = 0;
    do_solve("conv1", 10, 10486, 524288, 1, 0);
    chk("conv1.val", sx(dh_dyn_out[5]), longint'(5243));

    // wrap on revolute, plain add on prismatic
    jt_g = 6'b010101;
    for (int j = 0; j < NJ; j++) cur[j] = 3250586;
    do_solve("wrap", 1, 0, 524288, 3, 0);
    chk("wrap.rev", sx(dh_dyn_out[0]), longint'(3355444) - two_pi_v);
    chk("wrap.pri", sx(dh_dyn_out[1]), longint'(3355444));

    // clamped steps until the iteration limit
    jt_g = '0;
    for (int j = 0; j < NJ; j++) cur[j] = 0;
    do_solve("clamp", 4, 0, 262144, 2, 0);
    chk("clamp.val", sx(dh_dyn_out[2]), longint'(1048576));

    // prismatic saturation at both ends
    jt_g = '0;
    for (int j = 0; j < NJ; j++) cur[j] = (j % 2 == 0) ? wmax : wmin;
    do_solve("sat", 1, 0, 262144, 6, 0);

    // abort together with core_done on iteration 2
    jt_g = 6'b110011;
    for (int j = 0; j < NJ; j++) cur[j] = longint'(j) * 100000 - 250000;
    do_solve("abort", 10, 0, 300000, 0, 2);

    // most-negative delta counts as max positive against tolerance
    jt_g = '0;
    for (int j = 0; j < NJ; j++) cur[j] = 0;
    do_solve("minneg", 5, wmax, 262144, 5, 0);

    // max_iter of zero behaves as one
    jt_g = '1;
    for (int j = 0; j < NJ; j++) cur[j] = 0;
    do_solve("iter0", 0, 0, 262144, 2, 0);

    // asynchronous reset during RUN, then a fresh solve
    jt_g = '0;
    joint_type = jt_g;
    for (int j = 0; j < NJ; j++) dh_init[j] = W'(524288);
    max_iter = IW'(5); tol = W'(0); max_step = W'(262144);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rrun.core_en", longint'(core_en), longint'(1));
    #2 rst = 1'b1;
    #1;
    chk("rrun.core_en0", longint'(core_en), longint'(0));
    chk("rrun.busy0", longint'(busy), longint'(0));
    chk("rrun.dh0", sx(dh_dyn_out[0]), longint'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < NJ; j++) cur[j] = 0;
    do_solve("after_rst", 10, 10486, 524288, 1, 0);

    // randomized solves
    for (int n = 0; n < 25; n++) begin
      jt_g = NJ'($urandom);
      for (int j = 0; j < NJ; j++) begin
        if (jt_g[j]) cur[j] = longint'($urandom_range(0, 32'(two_pi_v))) - pi_v;
        else         cur[j] = sx(W'({$urandom, $urandom}));
      end
      do_solve($sformatf("rnd%0d", n), int'($urandom_range(0, 6)),
               longint'($urandom_range(0, 209715)),
               longint'($urandom_range(1, 32'(pi_v))),
               ($urandom_range(0, 3) == 0) ? 4 : 0,
               int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
